// File: rtl/classify_sweep_ctrl.sv
// Steps a 4-bit classifier input across [sw_start..sw_end] on auto ticks or button edges, latching flags/hit counts.
// First LED/count update lands 3 edges after start; start is ignored while busy, abort returns to IDLE at once.
module classify_sweep_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int TICK_W   = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       mode,
  input  logic       step_btn,
  input  logic [3:0] sw_start,
  input  logic [3:0] sw_end,
  output logic [3:0] cls_a,
  input  logic       cls_div3,
  input  logic       cls_even,
  output logic       led_div3,
  output logic       led_even,
  output logic [4:0] div3_count,
  output logic [4:0] even_count,
  output logic       busy,
  output logic       sweep_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    APPLY  = 3'd2,
    SAMPLE = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_t            state;
  logic [3:0]        end_q;
  logic              btn_q;
  logic [TICK_W-1:0] tick;
  logic              advance;

  // Manual mode steps on the rising edge of the button so a held press moves only once.
  assign advance = mode ? (step_btn && !btn_q) : (tick == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cls_a      <= 4'd0;
      end_q      <= 4'd0;
      btn_q      <= 1'b0;
      tick       <= '0;
      led_div3   <= 1'b0;
      led_even   <= 1'b0;
      div3_count <= 5'd0;
      even_count <= 5'd0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      btn_q      <= step_btn;
      sweep_done <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            cls_a      <= sw_start;
            end_q      <= sw_end;
            div3_count <= 5'd0;
            even_count <= 5'd0;
            state      <= APPLY;
          end
          APPLY: state <= SAMPLE;
          SAMPLE: begin
            led_div3   <= cls_div3;
            led_even   <= cls_even;
            div3_count <= div3_count + {4'd0, cls_div3};
            even_count <= even_count + {4'd0, cls_even};
            if (cls_a == end_q) begin
              state      <= DONE;
              sweep_done <= 1'b1;
            end else begin
              state <= WAIT;
              tick  <= '0;
            end
          end
          WAIT: begin
            if (advance) begin
              cls_a <= cls_a + 4'd1;
              tick  <= '0;
              state <= APPLY;
            end else if (mode) begin
              tick <= '0;
            end else begin
              tick <= tick + 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_classify_sweep_ctrl.sv
// Directed bench for classify_sweep_ctrl with a behavioural 4-bit classifier and a short tick divider.
module tb_classify_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       mode;
  logic       step_btn;
  logic [3:0] sw_start;
  logic [3:0] sw_end;
  logic [3:0] cls_a;
  logic       cls_div3;
  logic       cls_even;
  logic       led_div3;
  logic       led_even;
  logic [4:0] div3_count;
  logic [4:0] even_count;
  logic       busy;
  logic       sweep_done;

  int checks = 0;
  int errors = 0;

  classify_sweep_ctrl #(.TICK_DIV(4), .TICK_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .step_btn   (step_btn),
    .sw_start   (sw_start),
    .sw_end     (sw_end),
    .cls_a      (cls_a),
    .cls_div3   (cls_div3),
    .cls_even   (cls_even),
    .led_div3   (led_div3),
    .led_even   (led_even),
    .div3_count (div3_count),
    .even_count (even_count),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  // External classifier: nonzero multiple of 3, nonzero even.
  assign cls_div3 = (cls_a != 4'd0) && ((cls_a % 4'd3) == 4'd0);
  assign cls_even = (cls_a != 4'd0) && !cls_a[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start, then follows the sweep until busy drops, recording visited values.
  task automatic run_sweep(input logic [3:0] s, input logic [3:0] e, input int budget,
                           output int len, output int seq_err, output int pulses, output int fall_gap);
    logic [3:0] last;
    logic [3:0] nx;
    int cyc;
    int pulse_cyc;
    sw_start = s;
    sw_end   = e;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    len       = 1;
    seq_err   = (cls_a !== s) ? 1 : 0;
    last      = cls_a;
    pulses    = 0;
    pulse_cyc = -100;
    cyc       = 0;
    while (busy === 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cls_a !== last) begin
        nx = s + 4'(len);
        if (cls_a !== nx) seq_err++;
        len++;
        last = cls_a;
      end
      if (sweep_done === 1'b1) begin
        pulses++;
        pulse_cyc = cyc;
      end
    end
    fall_gap = (busy === 1'b1) ? -1 : cyc - pulse_cyc;
  endtask

  initial begin
    int len, seq_err, pulses, fall_gap, cyc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; step_btn = 1'b0;
    sw_start = 4'd0; sw_end = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_cls_a", 32'(cls_a), 0);
    chk("rst_led_div3", 32'(led_div3), 0);
    chk("rst_led_even", 32'(led_even), 0);
    chk("rst_div3_count", 32'(div3_count), 0);
    chk("rst_even_count", 32'(even_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sweep_done", 32'(sweep_done), 0);

    // Single-value sweep at 6: exact latency.
    sw_start = 4'd6; sw_end = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("one_busy_load", 32'(busy), 1);
    @(negedge clk);
    chk("one_cls_a", 32'(cls_a), 6);
    @(negedge clk);
    chk("one_led_before_sample", 32'(led_div3), 0);
    chk("one_done_early", 32'(sweep_done), 0);
    @(negedge clk);
    chk("one_led_div3", 32'(led_div3), 1);
    chk("one_led_even", 32'(led_even), 1);
    chk("one_div3_count", 32'(div3_count), 1);
    chk("one_even_count", 32'(even_count), 1);
    chk("one_sweep_done", 32'(sweep_done), 1);
    chk("one_busy_done", 32'(busy), 1);
    @(negedge clk);
    chk("one_done_cleared", 32'(sweep_done), 0);
    chk("one_idle", 32'(busy), 0);

    // Full 0..15 auto sweep.
    run_sweep(4'd0, 4'd15, 400, len, seq_err, pulses, fall_gap);
    chk("full_timeout", 32'(busy), 0);
    chk("full_len", 32'(len), 16);
    chk("full_seq_err", 32'(seq_err), 0);
    chk("full_pulses", 32'(pulses), 1);
    chk("full_fall_gap", 32'(fall_gap), 1);
    chk("full_div3_count", 32'(div3_count), 5);
    chk("full_even_count", 32'(even_count), 7);
    chk("full_led_div3", 32'(led_div3), 1);
    chk("full_led_even", 32'(led_even), 0);

    // Wrapping sweep 14,15,0,1.
    run_sweep(4'd14, 4'd1, 200, len, seq_err, pulses, fall_gap);
    chk("wrap_len", 32'(len), 4);
    chk("wrap_seq_err", 32'(seq_err), 0);
    chk("wrap_pulses", 32'(pulses), 1);
    chk("wrap_div3_count", 32'(div3_count), 1);
    chk("wrap_even_count", 32'(even_count), 1);
    chk("wrap_led_div3", 32'(led_div3), 0);
    chk("wrap_last_value", 32'(cls_a), 1);

    // Manual mode: held button advances once.
    mode = 1'b1; sw_start = 4'd2; sw_end = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("man_wait_value", 32'(cls_a), 2);
    chk("man_wait_busy", 32'(busy), 1);
    step_btn = 1'b1;
    repeat (20) @(negedge clk);
    chk("man_hold_one_step", 32'(cls_a), 3);
    step_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("man_release_hold", 32'(cls_a), 3);
    pulses = 0;
    for (int p = 0; p < 2; p++) begin
      step_btn = 1'b1;
      @(negedge clk);
      if (sweep_done === 1'b1) pulses++;
      step_btn = 1'b0;
      repeat (7) begin
        @(negedge clk);
        if (sweep_done === 1'b1) pulses++;
      end
    end
    chk("man_pulses", 32'(pulses), 1);
    chk("man_final_value", 32'(cls_a), 4);
    chk("man_busy", 32'(busy), 0);
    chk("man_div3_count", 32'(div3_count), 1);
    chk("man_even_count", 32'(even_count), 2);
    chk("man_led_even", 32'(led_even), 1);
    mode = 1'b0;

    // End latched at LOAD; start while busy ignored; abort at 7.
    sw_start = 4'd0; sw_end = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    sw_end = 4'd3;
    pulses = 0;
    cyc = 0;
    while (cls_a !== 4'd7 && cyc < 200) begin
      start = (cls_a == 4'd5);
      @(negedge clk);
      cyc++;
      if (sweep_done === 1'b1) pulses++;
    end
    start = 1'b0;
    chk("abort_reached_7", 32'(cls_a), 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_no_done", 32'(sweep_done), 0);
    repeat (3) begin
      @(negedge clk);
      if (sweep_done === 1'b1) pulses++;
    end
    chk("abort_pulses", 32'(pulses), 0);
    chk("abort_cls_a", 32'(cls_a), 7);
    chk("abort_div3_count", 32'(div3_count), 2);
    chk("abort_even_count", 32'(even_count), 3);
    chk("abort_led_div3", 32'(led_div3), 1);
    chk("abort_led_even", 32'(led_even), 1);

    // start and abort together in IDLE: stays idle.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", 32'(busy), 0);
    chk("start_abort_cls_a", 32'(cls_a), 7);

    // Reset in WAIT mid-sweep, then a fresh sweep.
    sw_start = 4'd0; sw_end = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    chk("mid_cls_a", 32'(cls_a), 3);
    chk("mid_div3_count", 32'(div3_count), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_cls_a", 32'(cls_a), 0);
    chk("mrst_led_div3", 32'(led_div3), 0);
    chk("mrst_led_even", 32'(led_even), 0);
    chk("mrst_div3_count", 32'(div3_count), 0);
    chk("mrst_even_count", 32'(even_count), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_sweep_done", 32'(sweep_done), 0);
    run_sweep(4'd5, 4'd9, 200, len, seq_err, pulses, fall_gap);
    chk("fresh_len", 32'(len), 5);
    chk("fresh_seq_err", 32'(seq_err), 0);
    chk("fresh_pulses", 32'(pulses), 1);
    chk("fresh_div3_count", 32'(div3_count), 2);
    chk("fresh_even_count", 32'(even_count), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
